// File: rtl/jzjpcc_mem_arbiter.sv
// Shares the single memory port between instruction fetch and execute-stage data accesses.
// One transaction in flight; data has priority, with a starvation counter forcing fetch through.
module jzjpcc_mem_arbiter #(
    parameter int unsigned PC_MAX_B     = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              fetch_req,
    input  logic [PC_MAX_B:2] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [31:0]       fetch_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [29:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_be,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [29:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StBusyFetch,
        StBusyData,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        fetch_rvalid_q, fetch_rvalid_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic [31:0] fetch_rdata_q, fetch_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic idle;
    logic data_wins;

    assign idle      = (state_q == StIdle);
    assign data_wins = data_req && !(fetch_req && (starve_q == Limit));

    // Grants are combinational; masked while reset is held so every output reads 0.
    assign data_gnt  = idle && data_wins && !reset;
    assign fetch_gnt = idle && !data_wins && fetch_req && !reset;

    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        fetch_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        fetch_rdata_d  = fetch_rdata_q;
        data_rdata_d   = data_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (data_wins) begin
                    state_d     = StBusyData;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    mem_be_d    = data_be;
                    if (fetch_req) begin
                        starve_d = (starve_q >= Limit) ? Limit : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (fetch_req) begin
                    state_d     = StBusyFetch;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 30'(fetch_addr);
                    mem_wdata_d = 32'd0;
                    mem_be_d    = 4'b1111;
                    starve_d    = 4'd0;
                end else begin
                    starve_d = 4'd0;
                end
            end
            StBusyFetch: begin
                if (mem_ack) begin
                    state_d        = StResp;
                    mem_req_d      = 1'b0;
                    fetch_rdata_d  = mem_rdata;
                    fetch_rvalid_d = 1'b1;
                end
            end
            StBusyData: begin
                if (mem_ack) begin
                    state_d       = StResp;
                    mem_req_d     = 1'b0;
                    data_rdata_d  = mem_rdata;
                    data_rvalid_d = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            starve_q       <= 4'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 30'd0;
            mem_wdata_q    <= 32'd0;
            mem_be_q       <= 4'd0;
            fetch_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            fetch_rdata_q  <= 32'd0;
            data_rdata_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            fetch_rdata_q  <= fetch_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign fetch_rvalid = fetch_rvalid_q;
    assign fetch_rdata  = fetch_rdata_q;
    assign data_rvalid  = data_rvalid_q;
    assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_jzjpcc_mem_arbiter.sv
// Bench for jzjpcc_mem_arbiter: directed protocol scenarios, then random traffic against a
// memory slave, with expected responses queued at issue and checked by a monitor.
module tb_jzjpcc_mem_arbiter;

    localparam int unsigned PcMaxB      = 15;
    localparam int unsigned StarveLimit = 4;
    localparam int          NTx         = 60;

    logic              clock = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [PcMaxB:2]   fetch_addr;
    logic              fetch_gnt, fetch_rvalid;
    logic [31:0]       fetch_rdata;
    logic              data_req, data_we;
    logic [29:0]       data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_be;
    logic              data_gnt, data_rvalid;
    logic [31:0]       data_rdata;
    logic              mem_req, mem_we;
    logic [29:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    jzjpcc_mem_arbiter #(
        .PC_MAX_B    (PcMaxB),
        .STARVE_LIMIT(StarveLimit)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_be     (data_be),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    txn_t        fq[$];
    txn_t        dq[$];
    logic [31:0] smem[logic [29:0]];
    logic [31:0] refm[logic [29:0]];
    int          tests = 0;
    int          fails = 0;
    logic        done  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] srd(input logic [29:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rrd(input logic [29:0] a);
        return refm.exists(a) ? refm[a] : init_word(a);
    endfunction

    task automatic wait_gnt(output logic f, output logic d);
        f = 1'b0;
        d = 1'b0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clock);
            if (fetch_gnt || data_gnt) begin
                f = fetch_gnt;
                d = data_gnt;
                break;
            end
        end
    endtask

    // Ack the transaction currently on the bus after one busy cycle; leaves us in RESP.
    task automatic ack_now(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic fetch_driver();
        txn_t t;
        logic got;
        for (int n = 0; n < NTx; n++) begin
            repeat ($urandom_range(0, 3)) step();
            fetch_addr = 14'($urandom);
            t.we    = 1'b0;
            t.addr  = 30'(fetch_addr);
            t.wdata = 32'd0;
            t.be    = 4'b1111;
            t.rdata = init_word(t.addr);
            fq.push_back(t);
            fetch_req = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                @(negedge clock);
                got = fetch_gnt;
            end
            if (!got) begin
                chk("fetch_gnt_timeout", 0, 1);
                break;
            end
            step();
            fetch_req = 1'b0;
        end
    endtask

    task automatic data_driver();
        txn_t t;
        logic got;
        for (int n = 0; n < NTx; n++) begin
            repeat ($urandom_range(0, 3)) step();
            t.we    = 1'($urandom_range(0, 1));
            t.addr  = 30'h0100_0000 | 30'($urandom_range(0, 15));
            t.wdata = $urandom;
            t.be    = 4'($urandom_range(1, 15));
            t.rdata = rrd(t.addr);
            if (t.we) refm[t.addr] = merge(rrd(t.addr), t.wdata, t.be);
            dq.push_back(t);
            data_we    = t.we;
            data_addr  = t.addr;
            data_wdata = t.wdata;
            data_be    = t.be;
            data_req   = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                @(negedge clock);
                got = data_gnt;
            end
            if (!got) begin
                chk("data_gnt_timeout", 0, 1);
                break;
            end
            step();
            data_req = 1'b0;
        end
    endtask

    task automatic slave();
        int dly = -1;
        while (!done) begin
            step();
            mem_ack = 1'b0;
            if (mem_req) begin
                if (dly < 0) dly = $urandom_range(0, 2);
                if (dly == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = srd(mem_addr);
                    if (mem_we) smem[mem_addr] = merge(srd(mem_addr), mem_wdata, mem_be);
                    dly = -1;
                end else begin
                    dly--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
        mem_ack = 1'b0;
    endtask

    // Tracks the arbiter from the outside: idle -> busy on a grant, busy -> resp on ack,
    // resp -> idle. Winner follows the priority rule with a count of denied fetches.
    task automatic monitor();
        int   ph     = 0;
        int   denied = 0;
        logic own_f  = 1'b0;
        logic ed, ef;
        txn_t t;
        while (!done) begin
            @(negedge clock);
            if (ph == 0) begin
                ed = data_req && !(fetch_req && denied == int'(StarveLimit));
                ef = !ed && fetch_req;
                chk("arb_gnt", {fetch_gnt, data_gnt}, {ef, ed});
                chk("idle_quiet", {mem_req, fetch_rvalid, data_rvalid}, 0);
                if (fetch_req && ed) denied = (denied < int'(StarveLimit)) ? denied + 1 : denied;
                else denied = 0;
                if (ef || ed) begin
                    ph    = 1;
                    own_f = ef;
                end
            end else if (ph == 1) begin
                chk("busy_sig", {fetch_gnt, data_gnt, fetch_rvalid, data_rvalid, mem_req},
                    5'b00001);
                if (own_f ? fq.size() == 0 : dq.size() == 0) begin
                    chk("busy_no_expected", 0, 1);
                end else if (own_f) begin
                    t = fq[0];
                    chk("fetch_cmd", {mem_we, mem_be, mem_addr}, {1'b0, 4'hf, t.addr});
                end else begin
                    t = dq[0];
                    chk("data_cmd", {mem_we, mem_be, mem_addr}, {t.we, t.be, t.addr});
                    if (t.we) chk("data_wdata", mem_wdata, t.wdata);
                end
                if (mem_ack) ph = 2;
            end else begin
                chk("resp_sig", {fetch_gnt, data_gnt, mem_req, fetch_rvalid, data_rvalid},
                    {3'b000, own_f, !own_f});
                if (own_f && fq.size() > 0) begin
                    t = fq.pop_front();
                    chk("fetch_rdata", fetch_rdata, t.rdata);
                end else if (!own_f && dq.size() > 0) begin
                    t = dq.pop_front();
                    if (!t.we) chk("data_rdata", data_rdata, t.rdata);
                end
                ph = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic f, d;
        reset = 1'b1;
        fetch_req = 1'b1; fetch_addr = '0;
        data_req = 1'b1; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clock);
        chk("reset_outputs", {fetch_gnt, data_gnt, fetch_rvalid, data_rvalid, mem_req, mem_we,
                              mem_be}, 0);
        chk("reset_bus", {mem_addr, mem_wdata}, 0);
        fetch_req = 1'b0; data_req = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Spurious ack in IDLE is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hbad0_bad0;
        @(negedge clock);
        chk("spur_ack_c0", {mem_req, fetch_rvalid, data_rvalid}, 0);
        step();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("spur_ack_c1", {mem_req, fetch_rvalid, data_rvalid, fetch_rdata}, 0);

        // Lone fetch with a 2-cycle ack.
        step();
        fetch_req = 1'b1; fetch_addr = 14'h0010;
        @(negedge clock);
        chk("lone_gnt", {fetch_gnt, data_gnt}, 2'b10);
        step();
        fetch_req = 1'b0;
        @(negedge clock);
        chk("lone_c1", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hf, 30'h10});
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clock);
        chk("lone_c2", {mem_req, fetch_rvalid}, 2'b10);
        step();
        mem_ack = 1'b0;
        data_req = 1'b1; data_we = 1'b0; data_addr = 30'h55;
        @(negedge clock);
        chk("lone_c3", {fetch_rvalid, data_rvalid, mem_req, fetch_rdata},
            {3'b100, 32'h0000_0013});
        chk("resp_no_gnt", {fetch_gnt, data_gnt}, 0);
        step();
        @(negedge clock);
        chk("after_resp_gnt", {fetch_gnt, data_gnt, fetch_rvalid}, 3'b010);
        step();
        data_req = 1'b0;
        ack_now(32'hcafe_f00d);
        @(negedge clock);
        chk("data_read_resp", {data_rvalid, fetch_rvalid, data_rdata}, {2'b10, 32'hcafe_f00d});
        chk("fetch_rdata_held", fetch_rdata, 32'h0000_0013);

        // Simultaneous requests: data wins, fetch next.
        step();
        fetch_req = 1'b1; fetch_addr = 14'h0020;
        data_req = 1'b1; data_we = 1'b1; data_addr = 30'h400; data_be = 4'b0011;
        data_wdata = 32'hdead_beef;
        @(negedge clock);
        chk("sim_gnt", {fetch_gnt, data_gnt}, 2'b01);
        step();
        data_req = 1'b0;
        @(negedge clock);
        chk("sim_cmd", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
            {1'b1, 1'b1, 4'b0011, 30'h400, 32'hdead_beef});
        chk("sim_busy_no_gnt", {fetch_gnt, data_gnt}, 0);
        ack_now(32'h0);
        @(negedge clock);
        chk("sim_wresp", {data_rvalid, fetch_rvalid}, 2'b10);
        wait_gnt(f, d);
        chk("sim_fetch_next", {f, d}, 2'b10);
        step();
        fetch_req = 1'b0;
        ack_now(32'h1111_2222);
        @(negedge clock);
        chk("sim_fetch_resp", {fetch_rvalid, fetch_rdata}, {1'b1, 32'h1111_2222});

        // Both held continuously: data wins StarveLimit times, then fetch, then data again.
        step();
        fetch_req = 1'b1; fetch_addr = 14'h0030;
        data_req = 1'b1; data_we = 1'b0; data_addr = 30'h77;
        for (int k = 0; k < int'(StarveLimit) + 2; k++) begin
            wait_gnt(f, d);
            chk($sformatf("starve_arb%0d", k), {f, d},
                (k == int'(StarveLimit)) ? 2'b10 : 2'b01);
            step();
            if (k == int'(StarveLimit) + 1) begin
                fetch_req = 1'b0;
                data_req  = 1'b0;
            end
            ack_now(32'h0);
        end
        @(negedge clock);
        chk("starve_last_resp", {data_rvalid, fetch_rvalid}, 2'b10);

        // Reset while a data access is on the bus.
        step();
        data_req = 1'b1; data_we = 1'b1; data_addr = 30'h99; data_be = 4'hf;
        data_wdata = 32'h1234_5678;
        wait_gnt(f, d);
        chk("rst_mid_gnt", {f, d}, 2'b01);
        step();
        data_req = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {fetch_gnt, data_gnt, fetch_rvalid, data_rvalid, mem_req, mem_we,
                                mem_be, mem_addr, mem_wdata}, 0);
        step();
        reset = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("rst_no_rvalid", {data_rvalid, fetch_rvalid, mem_req}, 0);
        end
        step();
        fetch_req = 1'b1; fetch_addr = 14'h0044;
        wait_gnt(f, d);
        chk("rst_fetch_gnt", {f, d}, 2'b10);
        step();
        fetch_req = 1'b0;
        ack_now(32'h0000_0013);
        @(negedge clock);
        chk("rst_fetch_resp", {fetch_rvalid, fetch_rdata}, {1'b1, 32'h0000_0013});

        // Random traffic.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        fork
            begin
                fork
                    fetch_driver();
                    data_driver();
                join
                for (int w = 0; w < 200 && (fq.size() != 0 || dq.size() != 0); w++) step();
                chk("drain", fq.size() + dq.size(), 0);
                done = 1'b1;
            end
            slave();
            monitor();
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
